// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;
  localparam logic [1:0] GP_ALU   = 2'b00;
  localparam logic [1:0] GP_MEM   = 2'b01;
  localparam logic [1:0] GP_SHIFT = 2'b10;
  localparam logic [1:0] GP_LINK  = 2'b11;
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: clearable saturating wait counter; limit_hit flags the last tolerated wait cycle
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_limit_hit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != W'(LIMIT)) r_cnt <= r_cnt + W'(1);
  end
  // hit while the LIMIT-th consecutive wait cycle is in progress
  assign o_limit_hit = i_en && (r_cnt >= W'(LIMIT - 1));
endmodule

// File: rtl/mips_cycle_controller.sv
// mips_cycle_controller: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake
module mips_cycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             GP_WE_dec,
  input  logic             DM_WE_dec,
  input  logic [1:0]       GP_MUX_SEL,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_is_fetch,
  output logic             ir_we,
  output logic             pc_we,
  output logic             gp_we,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);
  state_t     r_state, w_next;
  logic       w_limit;
  logic       w_active;
  logic [CNT_W-1:0] r_retired, r_cycles;
  assign mem_req      = (r_state == S_FETCH) || (r_state == S_MEM);
  assign mem_is_fetch = (r_state != S_MEM);
  assign ir_we        = (r_state == S_FETCH) && mem_ack;
  assign pc_we        = (r_state == S_WB);
  assign gp_we        = (r_state == S_WB) && GP_WE_dec;
  assign dm_we        = (r_state == S_MEM) && DM_WE_dec;
  assign bus_err      = (r_state == S_ERR);
  assign state        = r_state;
  assign retired      = r_retired;
  assign cycles       = r_cycles;
  assign w_active     = !(r_state inside {S_IDLE, S_HALT, S_ERR});
  // FETCH and MEM are never adjacent, so clearing outside them equals clearing on entry
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk         (clk),
    .rst_n       (rst),
    .i_clr       (!mem_req),
    .i_en        (mem_req && !mem_ack),
    .o_limit_hit (w_limit)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: w_next = start ? S_FETCH : r_state;
      S_FETCH:        w_next = mem_ack ? S_DECODE : (w_limit ? S_ERR : S_FETCH);
      S_DECODE:       w_next = S_EXEC;
      S_EXEC:         w_next = (DM_WE_dec || GP_MUX_SEL == GP_MEM) ? S_MEM : S_WB;
      S_MEM:          w_next = mem_ack ? S_WB : (w_limit ? S_ERR : S_MEM);
      S_WB:           w_next = halt_req ? S_HALT : S_FETCH;
      default:        w_next = S_ERR;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      r_state   <= w_next;
      r_retired <= r_retired + CNT_W'(r_state == S_WB);
      r_cycles  <= r_cycles + CNT_W'(w_active);
    end
  end
endmodule

// File: doc/mips_cycle_controller.md
# mips_cycle_controller

Multicycle sequencer for the MIPS datapath. It replaces the single fetch/execute toggle with an explicit FSM that steps each instruction through fetch, decode, execute, optional memory and write-back. It drives the write enables for the instruction register, PC, register file and data memory, and runs a req/ack handshake with the shared instruction/data memory. It sits between `instruction_decoder`, which supplies the decoded control, and the storage elements.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: wait cycles allowed for `mem_ack` before a bus error.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  input  1  — single clock; all state changes on the rising edge.
- `rst`  input  1  — asynchronous, active-low reset.
- `start`  input  1  — leave IDLE/HALT and begin fetching.
- `halt_req`  input  1  — stop after the current instruction retires.
- `GP_WE_dec`  input  1  — decoded register-file write enable.
- `DM_WE_dec`  input  1  — decoded data-memory write enable.
- `GP_MUX_SEL`  input  2  — decoded write-back source; 01 = load.
- `mem_ack`  input  1  — memory completes the current request.
- `mem_req`  output  1  — memory request; held until acknowledged.
- `mem_is_fetch`  output  1  — 1 = instruction fetch, 0 = data access.
- `ir_we`  output  1  — latch the fetched instruction.
- `pc_we`  output  1  — load `nextPC` into the PC.
- `gp_we`  output  1  — gated register-file write strobe.
- `dm_we`  output  1  — gated data-memory write strobe.
- `state`  output  3  — current FSM state.
- `bus_err`  output  1  — sticky; set when a memory access times out.
- `retired`  output  `CNT_W`  — count of retired instructions.
- `cycles`  output  `CNT_W`  — count of active cycles.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: if `start` → FETCH; otherwise stay.
- FETCH: `mem_req`=1 and `mem_is_fetch`=1. On `mem_ack`, assert `ir_we` in the same cycle → DECODE.
- DECODE: one cycle → EXEC.
- EXEC: if `DM_WE_dec`=1 or `GP_MUX_SEL`=01 → MEM; otherwise → WB.
- MEM: `mem_req`=1, `mem_is_fetch`=0, and `dm_we`=`DM_WE_dec` while requesting. On `mem_ack` → WB.
- WB: for exactly one cycle, `gp_we`=`GP_WE_dec` and `pc_we`=1; `retired` increments. Then → HALT if `halt_req`, else → FETCH.
- HALT: if `start` → FETCH. ERR: terminal until reset; `bus_err`=1.
- `halt_req` is sampled only in WB. `start` is ignored outside IDLE/HALT.
- `mem_ack` is ignored while `mem_req`=0.
- Wait timer: clears on entry to FETCH/MEM and counts cycles with `mem_ack`=0. When the count reaches `MEM_TIMEOUT` with ack still low → ERR. If ack arrives in the same cycle the count reaches the limit, the ack wins.
- `cycles` increments in every state except IDLE, HALT and ERR.
- Both counters are unsigned and wrap modulo 2^`CNT_W`.
- `ir_we`, `pc_we`, `gp_we` and `dm_we` are never asserted outside their named states.

## Timing
- Reset (`rst`=0) forces, asynchronously:
  - state → IDLE;
  - all strobes, `mem_req` and `bus_err` → 0;
  - `mem_is_fetch` → 1;
  - both counters → 0.
- Reset mid-access drops `mem_req` immediately and produces no write strobe.
- Latency with zero-wait memory: ALU/shift/branch/jump instructions take 4 cycles (FETCH, DECODE, EXEC, WB); loads and stores take 5. Each memory wait cycle adds 1.
- Throughput: one instruction in flight; no overlap.
- All outputs are registered state decodes or state-gated decoder inputs. There is no combinational path from `mem_ack` to `mem_req`. `ir_we` depends combinationally on `mem_ack` only within FETCH.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state encoding constants;
  - the `GP_MUX_SEL` encodings (ALU=00, MEM=01, SHIFT=10, LINK=11);
  - the `PC_MUX_SEL` encodings.
- Sub-module `mem_wait_timer`: a clearable saturating counter with a `limit_hit` output, used for the FETCH/MEM timeout.
- The FSM and the counters stay in the top module.

## Test plan
- Reset released, `start` pulse, ALU instruction (`GP_WE_dec`=1, `GP_MUX_SEL`=00), `mem_ack` returned the same cycle → state sequence 1,2,3,5,1; `gp_we` and `pc_we` each high 1 cycle; `retired`=1, `cycles`=4.
- Load (`GP_MUX_SEL`=01) with 3 ack wait cycles in MEM → 8 cycles total; `dm_we`=0 throughout; `gp_we` asserted in WB only.
- Store (`DM_WE_dec`=1, `GP_WE_dec`=0) → `dm_we` tracks `mem_req` in MEM; `gp_we` never asserted.
- `mem_ack` held low in FETCH → ERR entered after 15 wait cycles; `bus_err`=1 and sticky; `start` has no effect. Ack arriving on wait cycle 15 → DECODE, no error.
- `halt_req` asserted in EXEC → retire, then HALT; `cycles` frozen; `start` → FETCH.
- `rst` low mid-MEM → same-cycle `mem_req`=0, state=0, counters=0, no strobe.
